// File: rtl/key_event_ctrl.sv
// Four-key debouncer with press/release/long-press detection, per-key pending
// slots, a round-robin arbiter and a first-word-fall-through event FIFO.
module key_event_ctrl #(
    parameter int unsigned DEB_CNT    = 15,
    parameter int unsigned LONG_CNT   = 50000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_key,
    output logic [1:0] evt_type,
    output logic [3:0] key_level,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0]  DEB_LAST  = 8'(DEB_CNT - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CNT - 1);

    localparam logic [1:0] EV_NONE    = 2'b00;
    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_LONG    = 2'b11;

    typedef enum logic [2:0] {
        S_REL,
        S_DEB_P,
        S_PRS,
        S_LONG,
        S_DEB_R
    } state_t;

    logic [3:0]    sync1_q, sync2_q;
    state_t        state_q [4];
    state_t        state_d [4];
    logic [7:0]    dcnt_q  [4];
    logic [7:0]    dcnt_d  [4];
    logic [31:0]   lcnt_q  [4];
    logic [31:0]   lcnt_d  [4];
    logic [3:0]    long_q, long_d;
    logic [3:0]    level_q, level_d;
    logic [1:0]    raise   [4];

    logic [1:0]    pend_q  [4];
    logic [1:0]    pend_d  [4];
    logic          drop;
    logic          ovf_q, ovf_d;

    logic [1:0]    rr_q;
    logic          grant_vld;
    logic [1:0]    grant_idx;
    logic [1:0]    cand;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full;
    logic          push, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            lcnt_d[i]  = lcnt_q[i];
            long_d[i]  = long_q[i];
            raise[i]   = EV_NONE;
            case (state_q[i])
                S_REL: begin
                    if (sync2_q[i]) begin
                        state_d[i] = S_DEB_P;
                        dcnt_d[i]  = '0;
                    end
                end
                S_DEB_P: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_REL;
                    end else if (dcnt_q[i] == DEB_LAST) begin
                        state_d[i] = S_PRS;
                        raise[i]   = EV_PRESS;
                        lcnt_d[i]  = '0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 8'd1;
                    end
                end
                S_PRS: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_DEB_R;
                        dcnt_d[i]  = '0;
                    end else if (lcnt_q[i] == LONG_LAST) begin
                        state_d[i] = S_LONG;
                        raise[i]   = EV_LONG;
                        long_d[i]  = 1'b1;
                    end else begin
                        lcnt_d[i] = lcnt_q[i] + 32'd1;
                    end
                end
                S_LONG: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = S_DEB_R;
                        dcnt_d[i]  = '0;
                    end
                end
                S_DEB_R: begin
                    // a glitch returns to the held state without re-reporting it
                    if (sync2_q[i]) begin
                        state_d[i] = long_q[i] ? S_LONG : S_PRS;
                    end else if (dcnt_q[i] == DEB_LAST) begin
                        state_d[i] = S_REL;
                        raise[i]   = EV_RELEASE;
                        long_d[i]  = 1'b0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 8'd1;
                    end
                end
                default: state_d[i] = S_REL;
            endcase
            level_d[i] = (state_d[i] == S_PRS) || (state_d[i] == S_LONG) ||
                         (state_d[i] == S_DEB_R);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= S_REL;
                dcnt_q[i]  <= '0;
                lcnt_q[i]  <= '0;
            end
            long_q  <= '0;
            level_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                lcnt_q[i]  <= lcnt_d[i];
            end
            long_q  <= long_d;
            level_q <= level_d;
        end
    end

    assign fifo_full = (count_q == CW'(FIFO_DEPTH));

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        cand      = rr_q;
        if (!fifo_full) begin
            for (int unsigned k = 1; k <= 4; k++) begin
                cand = rr_q + 2'(k);
                if (!grant_vld && (pend_q[cand] != EV_NONE)) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // a grant frees the slot first, so a same-edge raise on that key is not a drop
    always_comb begin
        drop = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            pend_d[i] = pend_q[i];
            if (grant_vld && (grant_idx == 2'(i))) begin
                pend_d[i] = EV_NONE;
            end
            if (raise[i] != EV_NONE) begin
                if (pend_d[i] == EV_NONE) begin
                    pend_d[i] = raise[i];
                end else begin
                    drop = 1'b1;
                end
            end
        end
        ovf_d = (ovf_q & ~ovf_clr) | drop;
    end

    assign push = grant_vld;
    assign pop  = evt_valid & evt_ready;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pend_q[i] <= EV_NONE;
            end
            ovf_q   <= 1'b0;
            rr_q    <= 2'd3;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                pend_q[i] <= pend_d[i];
            end
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (grant_vld) begin
                rr_q <= grant_idx;
            end
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {grant_idx, pend_q[grant_idx]};
        end
    end

    assign evt_valid             = (count_q != '0);
    assign {evt_key, evt_type}   = evt_valid ? mem_q[rd_q] : 4'b0000;
    assign key_level             = level_q;
    assign ovf                   = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: stimulus pushes expected events into a
// queue, an independent negedge monitor pops and compares on each handshake.
module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic [3:0] key_level;
    logic       ovf;
    logic       ovf_clr;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [3:0]  exp_q [$];
    logic [3:0]  mon_exp;
    logic        bounce_bad;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .DEB_CNT   (15),
        .LONG_CNT  (100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key  (evt_key),
        .evt_type (evt_type),
        .key_level(key_level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input logic [1:0] k, input logic [1:0] t);
        exp_q.push_back({k, t});
    endtask

    task automatic do_reset();
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        rst_n     = 1'b0;
        key_in    = 4'h0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_evt: actual key %0d type %0d required none (t=%0t)",
                             evt_key, evt_type, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("evt", {28'h0, evt_key, evt_type}, {28'h0, mon_exp});
                end
            end else if (!evt_valid) begin
                chk("idle_zero", {28'h0, evt_key, evt_type}, 32'h0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        key_in    = 4'h0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        #2;
        chk("rst_valid", evt_valid, 0);
        chk("rst_level", key_level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_keytype", {evt_key, evt_type}, 0);
        do_reset();

        // clean press on key 0
        key_in[0] = 1'b1;
        expect_evt(2'd0, 2'b01);
        tick(17);
        chk("press_level_e16", key_level, 4'b0000);
        tick(1);
        chk("press_level_e17", key_level, 4'b0001);
        chk("press_valid_e17", evt_valid, 0);
        tick(1);
        chk("press_valid_e18", evt_valid, 1);
        chk("press_key_e18", evt_key, 0);
        chk("press_type_e18", evt_type, 2'b01);
        key_in[0] = 1'b0;
        expect_evt(2'd0, 2'b10);
        tick(10);
        chk("release_deb_level", key_level, 4'b0001);
        tick(20);
        chk("release_level", key_level, 4'b0000);

        // bounce on key 1
        bounce_bad = 1'b0;
        repeat (3) begin
            key_in[1] = 1'b1;
            repeat (10) begin tick(1); if (key_level[1]) bounce_bad = 1'b1; end
            key_in[1] = 1'b0;
            repeat (10) begin tick(1); if (key_level[1]) bounce_bad = 1'b1; end
        end
        chk("bounce_level", bounce_bad, 0);
        key_in[1] = 1'b1;
        expect_evt(2'd1, 2'b01);
        tick(40);
        chk("bounce_hold_level", key_level, 4'b0010);
        key_in[1] = 1'b0;
        expect_evt(2'd1, 2'b10);
        tick(30);

        // long press on key 2 with a short release glitch
        key_in[2] = 1'b1;
        expect_evt(2'd2, 2'b01);
        expect_evt(2'd2, 2'b11);
        tick(118);
        chk("long_valid_e117", evt_valid, 0);
        tick(1);
        chk("long_valid_e118", evt_valid, 1);
        chk("long_key", evt_key, 2);
        chk("long_type", evt_type, 2'b11);
        tick(30);
        key_in[2] = 1'b0;
        tick(8);
        key_in[2] = 1'b1;
        tick(30);
        chk("glitch_level", key_level, 4'b0100);
        key_in[2] = 1'b0;
        expect_evt(2'd2, 2'b10);
        tick(30);
        chk("long_rel_level", key_level, 4'b0000);

        // contention: all keys on the same edge, rr_ptr=3 after reset
        do_reset();
        key_in = 4'hF;
        for (int k = 0; k < 4; k++) expect_evt(2'(k), 2'b01);
        tick(18);
        chk("cont_valid_e17", evt_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("cont_valid", evt_valid, 1);
            chk("cont_order", evt_key, k);
        end
        tick(1);
        chk("cont_empty", evt_valid, 0);
        key_in = 4'h0;
        for (int k = 0; k < 4; k++) expect_evt(2'(k), 2'b10);
        tick(30);

        // backpressure, drop and overflow
        do_reset();
        evt_ready = 1'b0;
        key_in = 4'hF;
        for (int k = 0; k < 4; k++) expect_evt(2'(k), 2'b01);
        tick(25);
        chk("bp_head_key", evt_key, 0);
        chk("bp_head_type", evt_type, 2'b01);
        key_in = 4'b1100;
        expect_evt(2'd0, 2'b10);
        expect_evt(2'd1, 2'b10);
        tick(25);
        chk("bp_ovf_before", ovf, 0);
        chk("bp_level", key_level, 4'b1100);
        key_in[0] = 1'b1;
        tick(25);
        chk("bp_ovf_set", ovf, 1);
        chk("bp_head_held", {evt_valid, evt_key, evt_type}, 5'b1_00_01);
        key_in = 4'h0;
        evt_ready = 1'b1;
        expect_evt(2'd2, 2'b10);
        expect_evt(2'd3, 2'b10);
        expect_evt(2'd0, 2'b10);
        tick(40);
        chk("bp_drained", evt_valid, 0);
        chk("bp_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", ovf, 0);

        // async reset mid-debounce with a non-empty FIFO
        do_reset();
        evt_ready = 1'b0;
        key_in[3] = 1'b1;
        tick(25);
        chk("ar_valid_before", evt_valid, 1);
        chk("ar_key_before", evt_key, 3);
        chk("ar_level_before", key_level, 4'b1000);
        key_in[1] = 1'b1;
        tick(8);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", evt_valid, 0);
        chk("ar_keytype", {evt_key, evt_type}, 0);
        chk("ar_level", key_level, 0);
        chk("ar_ovf", ovf, 0);
        key_in = 4'h0;
        tick(3);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        tick(40);
        chk("ar_no_stale", evt_valid, 0);
        key_in[2] = 1'b1;
        expect_evt(2'd2, 2'b01);
        tick(25);
        key_in[2] = 1'b0;
        expect_evt(2'd2, 2'b10);
        tick(30);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
